// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: glyph table, invalid-digit code and scan decoder states.
// The display driver encodes from the same glyph table, so driver and checker always agree.
package sseg_pkg;

    localparam int DIGITS_DEFAULT = 4;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        COLLECT = 2'd1,
        LOST    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational inverse of the glyph table: active-high segment pattern to BCD digit.
// Patterns outside the table report valid=0 and the invalid-digit code.
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        digit = BCD_INVALID;
        case (seg)
            GLYPH_0: digit = 4'd0;
            GLYPH_1: digit = 4'd1;
            GLYPH_2: digit = 4'd2;
            GLYPH_3: digit = 4'd3;
            GLYPH_4: digit = 4'd4;
            GLYPH_5: digit = 4'd5;
            GLYPH_6: digit = 4'd6;
            GLYPH_7: digit = 4'd7;
            GLYPH_8: digit = 4'd8;
            GLYPH_9: digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Monitors a multiplexed seven-segment anode/cathode scan and rebuilds the displayed BCD frame.
// Reports invalid glyphs, frame stability and loss of scanning.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = DIGITS_DEFAULT,
    parameter int MIN_DWELL     = 4,
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT       = 4096,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   sseg_a_i,
    input  logic [6:0]              sseg_c_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    bcd_valid_o,
    output logic                    err_o,
    output logic                    stable_o,
    output logic                    lost_o
);

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int SW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);
    localparam logic [TW-1:0] TIME_MAX   = TW'(TIMEOUT);

    logic [NUM_DIGITS-1:0]   anode_raw, anode, anode_prev;
    logic [6:0]              seg_raw, seg, seg_prev;
    logic [DW-1:0]           dwell, dwell_next;
    logic [TW-1:0]           tcnt;
    logic [SW-1:0]           stable_cnt;
    logic [NUM_DIGITS-1:0]   seen;
    logic [4*NUM_DIGITS-1:0] slots;
    logic                    frame_err;
    logic                    qualify, same, capture, frame_done, timeout_hit;
    logic                    glyph_valid;
    logic [3:0]              glyph_digit;
    scan_state_t             state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_raw  <= '0;
            seg_raw    <= '0;
            anode_prev <= '0;
            seg_prev   <= '0;
            dwell      <= '0;
        end else begin
            anode_raw  <= sseg_a_i;
            seg_raw    <= sseg_c_i;
            anode_prev <= anode;
            seg_prev   <= seg;
            dwell      <= dwell_next;
        end
    end

    assign anode = anode_raw ^ {NUM_DIGITS{ACTIVE_LOW}};
    assign seg   = seg_raw ^ {7{ACTIVE_LOW}};

    assign qualify = (anode != '0) && ((anode & (anode - 1'b1)) == '0);
    assign same    = (anode == anode_prev) && (seg == seg_prev);

    always_comb begin
        dwell_next = '0;
        if (qualify) begin
            if (same && (dwell != '0))
                dwell_next = (dwell == DWELL_MAX) ? DWELL_MAX : dwell + 1'b1;
            else
                dwell_next = DW'(1);
        end
    end

    // A saturated dwell that is still unchanged has already been captured
    assign capture = qualify && (dwell_next == DWELL_MAX) && !(same && (dwell == DWELL_MAX));

    sseg_glyph_decode u_decode (
        .seg   (seg),
        .valid (glyph_valid),
        .digit (glyph_digit)
    );

    assign frame_done  = (state == COLLECT) && (seen == '1);
    assign timeout_hit = !capture && (tcnt == TIME_MAX - 1'b1);
    assign stable_o    = (stable_cnt == STABLE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            seen        <= '0;
            slots       <= '0;
            frame_err   <= 1'b0;
            tcnt        <= '0;
            stable_cnt  <= '0;
            bcd_o       <= '0;
            bcd_valid_o <= 1'b0;
            err_o       <= 1'b0;
            lost_o      <= 1'b0;
        end else begin
            bcd_valid_o <= 1'b0;

            if (capture)
                tcnt <= '0;
            else if (tcnt != TIME_MAX)
                tcnt <= tcnt + 1'b1;

            if (frame_done) begin
                bcd_o       <= slots;
                err_o       <= frame_err;
                bcd_valid_o <= 1'b1;
                if (!frame_err && (slots == bcd_o))
                    stable_cnt <= (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 1'b1;
                else
                    stable_cnt <= frame_err ? SW'(0) : SW'(1);
            end

            // A capture on the completion edge opens the next frame
            if (capture) begin
                seen      <= (frame_done ? '0 : seen) | anode;
                frame_err <= (frame_done ? 1'b0 : frame_err) | !glyph_valid;
                for (int k = 0; k < NUM_DIGITS; k++)
                    if (anode[k])
                        slots[4*k +: 4] <= glyph_digit;
                state  <= COLLECT;
                lost_o <= 1'b0;
            end else if (timeout_hit) begin
                state      <= LOST;
                lost_o     <= 1'b1;
                seen       <= '0;
                frame_err  <= 1'b0;
                stable_cnt <= '0;
            end else if (frame_done) begin
                seen      <= '0;
                frame_err <= 1'b0;
                state     <= SEARCH;
            end
        end
    end

endmodule
